program_loader: RTL and testbench

//  Writes a program image into the CPU's 16-byte RAM from the host pins, one byte per strobe.

---
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - host-pin program image loader into the CPU RAM write port
//
// Purpose:
//   Accepts a program image one byte per strobe rise from the chip pins and writes
//   it into the CPU RAM. The CPU is held in reset while a load is in progress and
//   released once the loader is back in IDLE, so execution starts from address 0.
//   Optional trailing checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous reset, active-low
//   load_req_i   in   async pin, high = host requests/continues a load
//   strobe_i     in   async pin, rising edge = data_i holds a valid byte
//   data_i       in   program byte (held stable around the strobe rise)
//   ram_addr_o   out  RAM write address
//   ram_data_o   out  RAM write data
//   ram_we_o     out  RAM write enable, single-cycle pulse
//   cpu_rst_n_o  out  CPU core reset, active-low
//   busy_o       out  high while the loader is not IDLE
//   done_o       out  one-cycle pulse when a complete image has been accepted
//   chk_err_o    out  sticky checksum mismatch flag (0 without the checksum option)

module program_loader #(
   parameter int DW        = 8,
   parameter int AW        = 4,
   parameter int NUM_BYTES = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_req_i,
   input  logic          strobe_i,
   input  logic [DW-1:0] data_i,
   output logic [AW-1:0] ram_addr_o,
   output logic [DW-1:0] ram_data_o,
   output logic          ram_we_o,
   output logic          cpu_rst_n_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          chk_err_o
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1} state_t;
`endif

   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BYTES - 1);

   state_t        state;
   logic [AW-1:0] addr_cnt;
   logic          load_s1, load_s2;
   logic          strobe_s1, strobe_s2, strobe_s3;
   logic          rise;

   assign rise   = strobe_s2 & ~strobe_s3;
   assign busy_o = (state != IDLE);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [DW-1:0] sum;
   logic [DW-1:0] sum_next;
   logic          chk_err_q;

   assign sum_next  = sum + data_i;
   assign chk_err_o = chk_err_q;
`else
   assign chk_err_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr_cnt    <= '0;
         load_s1     <= 1'b0;
         load_s2     <= 1'b0;
         strobe_s1   <= 1'b0;
         strobe_s2   <= 1'b0;
         strobe_s3   <= 1'b0;
         ram_we_o    <= 1'b0;
         ram_addr_o  <= '0;
         ram_data_o  <= '0;
         cpu_rst_n_o <= 1'b0;
         done_o      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum         <= '0;
         chk_err_q   <= 1'b0;
`endif
      end else begin
         load_s1   <= load_req_i;
         load_s2   <= load_s1;
         strobe_s1 <= strobe_i;
         strobe_s2 <= strobe_s1;
         strobe_s3 <= strobe_s2;

         ram_we_o <= 1'b0;
         done_o   <= 1'b0;

         // Release the CPU only when IDLE now and staying IDLE: this gives the
         // one-cycle delay after entering IDLE and drops the reset in the same
         // edge that starts a load.
         cpu_rst_n_o <= (state == IDLE) && !load_s2;

         case (state)
            IDLE: begin
               if (load_s2) begin
                  state    <= LOAD;
                  addr_cnt <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  sum       <= '0;
                  chk_err_q <= 1'b0;
`endif
               end
            end

            LOAD: begin
               // Abort takes priority over a byte arriving in the same cycle.
               if (!load_s2) begin
                  state    <= IDLE;
                  addr_cnt <= '0;
               end else if (rise) begin
                  ram_addr_o <= addr_cnt;
                  ram_data_o <= data_i;
                  ram_we_o   <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  sum        <= sum_next;
`endif
                  if (addr_cnt == LAST_ADDR) begin
                     addr_cnt <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     state    <= CHECK;
`else
                     state    <= IDLE;
                     done_o   <= 1'b1;
`endif
                  end else begin
                     addr_cnt <= addr_cnt + AW'(1);
                  end
               end
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
               if (!load_s2) begin
                  state    <= IDLE;
                  addr_cnt <= '0;
               end else if (rise) begin
                  // Image sum plus checksum byte must vanish mod 2**DW.
                  chk_err_q <= (sum_next != '0);
                  done_o    <= 1'b1;
                  state     <= IDLE;
               end
            end
`endif

            default: begin
               state    <= IDLE;
               addr_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader

module tb_program_loader;

   logic       clk;
   logic       rst_n;
   logic       load_req_i;
   logic       strobe_i;
   logic [7:0] data_i;
   logic [3:0] ram_addr_o;
   logic [7:0] ram_data_o;
   logic       ram_we_o;
   logic       cpu_rst_n_o;
   logic       busy_o;
   logic       done_o;
   logic       chk_err_o;

   program_loader #(.DW(8), .AW(4), .NUM_BYTES(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_req_i  (load_req_i),
      .strobe_i    (strobe_i),
      .data_i      (data_i),
      .ram_addr_o  (ram_addr_o),
      .ram_data_o  (ram_data_o),
      .ram_we_o    (ram_we_o),
      .cpu_rst_n_o (cpu_rst_n_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .chk_err_o   (chk_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] wr_addr[$];
   logic [7:0] wr_data[$];
   int         done_cnt    = 0;
   int         done_we_cnt = 0;
   int         viol        = 0;
   logic       watch       = 1'b0;

   // Observe RAM writes, done pulses and CPU-reset/busy during a load window.
   always @(negedge clk) begin
      if (ram_we_o) begin
         wr_addr.push_back(ram_addr_o);
         wr_data.push_back(ram_data_o);
      end
      if (done_o) begin
         done_cnt++;
         if (ram_we_o) done_we_cnt++;
      end
      if (watch && (cpu_rst_n_o || !busy_o)) viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One byte per 8 clks; optionally drop load_req one clk after the strobe
   // rise so this byte is still accepted but the loader ends in IDLE.
   task automatic send_byte(input logic [7:0] b, input logic drop);
      data_i = b;
      clk_wait(1);
      strobe_i = 1'b1;
      clk_wait(1);
      if (drop) load_req_i = 1'b0;
      clk_wait(3);
      strobe_i = 1'b0;
      clk_wait(3);
   endtask

   int base;
   int d0;
   int dw0;

   initial begin
      rst_n      = 1'b0;
      load_req_i = 1'b0;
      strobe_i   = 1'b0;
      data_i     = 8'h00;

      // Reset hold
      clk_wait(3);
      check("rst_we",      32'(ram_we_o),    32'd0);
      check("rst_done",    32'(done_o),      32'd0);
      check("rst_cpu",     32'(cpu_rst_n_o), 32'd0);
      check("rst_busy",    32'(busy_o),      32'd0);
      check("rst_chk",     32'(chk_err_o),   32'd0);
      check("rst_addr",    32'(ram_addr_o),  32'd0);
      rst_n = 1'b1;
      clk_wait(2);
      check("rel_cpu",     32'(cpu_rst_n_o), 32'd1);

      // Full load 0x10..0x1F
      load_req_i = 1'b1;
      clk_wait(4);
      base = wr_addr.size();
      d0   = done_cnt;
      dw0  = done_we_cnt;
      watch = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      for (int i = 0; i < 16; i++) send_byte(8'(16 + i), 1'b0);
      watch = 1'b0;
      send_byte(8'h88, 1'b1);
      check("full_chk",    32'(chk_err_o),   32'd0);
      check("full_donewe", 32'(done_we_cnt - dw0), 32'd0);
`else
      for (int i = 0; i < 15; i++) send_byte(8'(16 + i), 1'b0);
      watch = 1'b0;
      send_byte(8'h1F, 1'b1);
      check("full_donewe", 32'(done_we_cnt - dw0), 32'd1);
      check("full_chk",    32'(chk_err_o),   32'd0);
`endif
      check("full_done",   32'(done_cnt - d0), 32'd1);
      check("full_nwr",    32'(wr_addr.size() - base), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("full_addr%0d", i), 32'(wr_addr[base + i]), 32'(i));
         check($sformatf("full_data%0d", i), 32'(wr_data[base + i]), 32'(16 + i));
      end
      check("full_viol",   32'(viol), 32'd0);
      clk_wait(3);
      check("full_cpu",    32'(cpu_rst_n_o), 32'd1);
      check("full_busy",   32'(busy_o),      32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Bad checksum byte 0x00 (image sum is 0x78)
      load_req_i = 1'b1;
      clk_wait(4);
      base = wr_addr.size();
      d0   = done_cnt;
      for (int i = 0; i < 16; i++) send_byte(8'(16 + i), 1'b0);
      send_byte(8'h00, 1'b1);
      check("bad_nwr",     32'(wr_addr.size() - base), 32'd16);
      check("bad_done",    32'(done_cnt - d0), 32'd1);
      check("bad_chk",     32'(chk_err_o), 32'd1);
      clk_wait(3);
      check("bad_sticky",  32'(chk_err_o), 32'd1);
      load_req_i = 1'b1;
      clk_wait(4);
      check("bad_clear",   32'(chk_err_o), 32'd0);
      load_req_i = 1'b0;
      clk_wait(6);
`endif

      // Abort after 5 bytes
      load_req_i = 1'b1;
      clk_wait(4);
      base = wr_addr.size();
      d0   = done_cnt;
      for (int i = 0; i < 5; i++) send_byte(8'(32 + i), 1'b0);
      load_req_i = 1'b0;
      clk_wait(6);
      check("abt_busy",    32'(busy_o),      32'd0);
      check("abt_cpu",     32'(cpu_rst_n_o), 32'd1);
      check("abt_done",    32'(done_cnt - d0), 32'd0);
      check("abt_nwr",     32'(wr_addr.size() - base), 32'd5);
      check("abt_addr4",   32'(wr_addr[base + 4]), 32'd4);
      load_req_i = 1'b1;
      clk_wait(4);
      send_byte(8'hA5, 1'b1);
      check("abt_new_nwr", 32'(wr_addr.size() - base), 32'd6);
      check("abt_new_adr", 32'(wr_addr[base + 5]), 32'd0);
      check("abt_new_dat", 32'(wr_data[base + 5]), 32'hA5);
      clk_wait(4);

      // Strobes while idle are ignored
      base = wr_addr.size();
      for (int i = 0; i < 4; i++) send_byte(8'(64 + i), 1'b0);
      check("idle_nwr",    32'(wr_addr.size() - base), 32'd0);
      check("idle_busy",   32'(busy_o), 32'd0);

      // Latency, and a long-held strobe writes once; first address is 0
      load_req_i = 1'b1;
      clk_wait(4);
      base = wr_addr.size();
      data_i = 8'h5A;
      clk_wait(1);
      strobe_i = 1'b1;
      clk_wait(1);
      check("lat_n",       32'(ram_we_o), 32'd0);
      clk_wait(1);
      check("lat_n1",      32'(ram_we_o), 32'd0);
      clk_wait(1);
      check("lat_n2",      32'(ram_we_o), 32'd1);
      check("lat_addr",    32'(ram_addr_o), 32'd0);
      check("lat_data",    32'(ram_data_o), 32'h5A);
      clk_wait(1);
      check("lat_n3",      32'(ram_we_o), 32'd0);
      clk_wait(6);
      strobe_i = 1'b0;
      clk_wait(3);
      check("lat_nwr",     32'(wr_addr.size() - base), 32'd1);

      // Reset in the middle of a load
      rst_n = 1'b0;
      clk_wait(1);
      check("mid_busy",    32'(busy_o),      32'd0);
      check("mid_cpu",     32'(cpu_rst_n_o), 32'd0);
      rst_n = 1'b1;
      load_req_i = 1'b0;
      clk_wait(3);
      check("mid_rel",     32'(cpu_rst_n_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
